array_7_queue_ctrl: RTL and testbench

- Ready/valid FIFO controller that owns the single-port 16x24 masked SRAM macro and drives its RW0 port.
- Converts a streaming enqueue/dequeue interface into one SRAM operation per cycle, either a write or a read.
- Handles the macro's 1-cycle read latency and adds an output register with an empty-queue bypass.
- Total capacity is DEPTH + 1 entries: DEPTH in SRAM plus one in the output register.

---
 rtl/array_7_queue_ctrl.sv | 113 +++++++++++
 tb/tb_array_7_queue_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/array_7_queue_ctrl.sv
// Ready/valid FIFO controller in front of a single-port masked SRAM macro.
// One SRAM operation per cycle; reads take priority and land in an output register with empty-queue bypass.
module array_7_queue_ctrl #(
    parameter int DEPTH    = 16,
    parameter int WIDTH    = 24,
    parameter int ADDR_W   = 4,
    parameter int MASK_SEG = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enq_valid,
    output logic              enq_ready,
    input  logic [WIDTH-1:0]  enq_bits,
    output logic              deq_valid,
    input  logic              deq_ready,
    output logic [WIDTH-1:0]  deq_bits,
    output logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en,
    output logic              mem_wmode,
    output logic [MASK_SEG-1:0] mem_wmask,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata
);

    localparam logic [ADDR_W:0] RAM_MAX = DEPTH[ADDR_W:0];

    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [ADDR_W-1:0] rd_ptr_reg;
    logic [ADDR_W:0]   ram_cnt_reg;
    logic              rd_pend_reg;
    logic              out_valid_reg;
    logic [WIDTH-1:0]  out_q_reg;

    logic deq_fire;
    logic out_free;
    logic ram_empty;
    logic ram_has_room;
    logic rd_issue;
    logic bypass_cond;
    logic bypass;
    logic wr;

    assign deq_fire     = out_valid_reg & deq_ready;
    assign out_free     = !out_valid_reg | deq_fire;
    assign ram_empty    = (ram_cnt_reg == '0);
    assign ram_has_room = (ram_cnt_reg < RAM_MAX);

    // Reads own the port whenever the output slot can take the result, which keeps FIFO order.
    assign rd_issue    = !reset & !ram_empty & !rd_pend_reg & out_free;
    assign bypass_cond = !reset & ram_empty & !rd_pend_reg & out_free;
    assign bypass      = enq_valid & bypass_cond;
    assign wr          = !reset & enq_valid & !bypass & !rd_issue & ram_has_room;

    assign enq_ready = bypass_cond | (!reset & ram_has_room & !rd_issue);
    assign deq_valid = out_valid_reg;
    assign deq_bits  = out_q_reg;
    assign count     = ram_cnt_reg + (ADDR_W+1)'(rd_pend_reg) + (ADDR_W+1)'(out_valid_reg);

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            ram_cnt_reg   <= '0;
            rd_pend_reg   <= 1'b0;
            out_valid_reg <= 1'b0;
            out_q_reg     <= '0;
        end else begin
            rd_pend_reg <= rd_issue;
            if (rd_issue) begin
                rd_ptr_reg  <= rd_ptr_reg + 1'b1;
                ram_cnt_reg <= ram_cnt_reg - 1'b1;
            end else if (wr) begin
                wr_ptr_reg  <= wr_ptr_reg + 1'b1;
                ram_cnt_reg <= ram_cnt_reg + 1'b1;
            end
            // Capture and bypass are mutually exclusive: bypass is blocked while a read is in flight.
            if (rd_pend_reg) begin
                out_q_reg     <= mem_rdata;
                out_valid_reg <= 1'b1;
            end else if (bypass) begin
                out_q_reg     <= enq_bits;
                out_valid_reg <= 1'b1;
            end else if (deq_fire) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_wmode = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (rd_issue) begin
            mem_en   = 1'b1;
            mem_addr = rd_ptr_reg;
        end else if (wr) begin
            mem_en    = 1'b1;
            mem_wmode = 1'b1;
            mem_addr  = wr_ptr_reg;
            mem_wdata = enq_bits;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < MASK_SEG; gi++) begin : g_wmask
            assign mem_wmask[gi] = wr;
        end
    endgenerate

endmodule

// File: tb/tb_array_7_queue_ctrl.sv
// Directed bench for array_7_queue_ctrl with a behavioural 1-cycle-latency SRAM model.
module tb_array_7_queue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        enq_valid;
    logic        enq_ready;
    logic [23:0] enq_bits;
    logic        deq_valid;
    logic        deq_ready;
    logic [23:0] deq_bits;
    logic [4:0]  count;
    logic [3:0]  mem_addr;
    logic        mem_en;
    logic        mem_wmode;
    logic [1:0]  mem_wmask;
    logic [23:0] mem_wdata;
    logic [23:0] mem_rdata = '0;

    logic [23:0] sram [16];
    logic        occ [16];
    logic [23:0] sb [$];

    int checks = 0;
    int errors = 0;

    array_7_queue_ctrl dut (
        .clock     (clk),
        .reset     (reset),
        .enq_valid (enq_valid),
        .enq_ready (enq_ready),
        .enq_bits  (enq_bits),
        .deq_valid (deq_valid),
        .deq_ready (deq_ready),
        .deq_bits  (deq_bits),
        .count     (count),
        .mem_addr  (mem_addr),
        .mem_en    (mem_en),
        .mem_wmode (mem_wmode),
        .mem_wmask (mem_wmask),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Macro model: synchronous write, read data registered one cycle after issue.
    always @(posedge clk) begin
        if (mem_en && mem_wmode) sram[mem_addr] <= mem_wdata;
        if (mem_en && !mem_wmode) mem_rdata <= sram[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc;
        int exp_val;
        int exp_addr;
        int enq_cnt;
        logic [23:0] front;

        reset = 1'b1; enq_valid = 1'b0; enq_bits = '0; deq_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin sram[i] = '0; occ[i] = 1'b0; end

        // 1: reset
        tick(); tick();
        reset = 1'b0; #1;
        chk("rst_deq_valid", deq_valid, 0);
        chk("rst_deq_bits", deq_bits, 0);
        chk("rst_count", count, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wmask", mem_wmask, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_enq_ready", enq_ready, 1);
        $display("txn reset: count=%0d enq_ready=%0b", count, enq_ready);

        // 2: bypass into empty queue
        tick();
        enq_valid = 1'b1; enq_bits = 24'hABC123; #1;
        chk("byp_enq_ready", enq_ready, 1);
        chk("byp_mem_en", mem_en, 0);
        tick();
        enq_valid = 1'b0; #1;
        chk("byp_deq_valid", deq_valid, 1);
        chk("byp_deq_bits", deq_bits, 24'hABC123);
        chk("byp_count", count, 1);
        chk("byp_mem_en_after", mem_en, 0);
        $display("txn bypass: deq_bits=%h count=%0d", deq_bits, count);
        deq_ready = 1'b1;
        tick();
        deq_ready = 1'b0; #1;
        chk("byp_drained_count", count, 0);

        // 3: fill to DEPTH+1
        for (int i = 1; i <= 17; i++) begin
            enq_valid = 1'b1; enq_bits = 24'(i); #1;
            chk("fill_enq_ready", enq_ready, 1);
            if (i == 1) begin
                chk("fill_bypass_no_mem", mem_en, 0);
            end else begin
                chk("fill_mem_en", mem_en, 1);
                chk("fill_wmode", mem_wmode, 1);
                chk("fill_addr", mem_addr, i - 2);
                chk("fill_wmask", mem_wmask, 2'b11);
                chk("fill_wdata", mem_wdata, i);
            end
            $display("txn enq: data=%0d count=%0d", i, count);
            tick();
        end
        enq_valid = 1'b0; #1;
        chk("full_count", count, 17);
        chk("full_enq_ready", enq_ready, 0);
        chk("full_deq_bits", deq_bits, 1);
        enq_valid = 1'b1; enq_bits = 24'hFFFFFF; #1;
        chk("full_enq_ready_offer", enq_ready, 0);
        chk("full_no_mem", mem_en, 0);
        enq_valid = 1'b0;

        // 4: drain from full
        deq_ready = 1'b1; exp_val = 1; exp_addr = 0; cyc = 0;
        while (exp_val <= 17 && cyc < 80) begin
            #1;
            if (mem_en) begin
                chk("drain_rd_wmode", mem_wmode, 0);
                chk("drain_rd_addr", mem_addr, exp_addr);
                exp_addr++;
            end
            if (deq_valid) begin
                chk("drain_deq_bits", deq_bits, exp_val);
                $display("txn deq: data=%0d cycle=%0d", deq_bits, cyc);
                exp_val++;
            end
            tick();
            cyc++;
        end
        chk("drain_all_seen", exp_val, 18);
        chk("drain_reads", exp_addr, 16);
        chk("drain_cycles", cyc, 33);
        chk("drain_count", count, 0);
        chk("drain_deq_valid", deq_valid, 0);
        deq_ready = 1'b0;

        // 5: random traffic with scoreboard
        enq_cnt = 0; cyc = 0;
        while ((enq_cnt < 40 || sb.size() != 0) && cyc < 3000) begin
            enq_valid = (enq_cnt < 40) ? 1'($urandom_range(0, 1)) : 1'b0;
            enq_bits  = 24'($urandom);
            deq_ready = (enq_cnt < 24) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            #1;
            chk("rnd_count", count, sb.size());
            if (mem_en && mem_wmode) begin
                chk("rnd_wr_free_slot", occ[mem_addr], 0);
                occ[mem_addr] = 1'b1;
            end
            if (mem_en && !mem_wmode) occ[mem_addr] = 1'b0;
            if (deq_valid && deq_ready) begin
                if (sb.size() == 0) begin
                    chk("rnd_deq_unexpected", 1, 0);
                end else begin
                    front = sb.pop_front();
                    chk("rnd_deq_bits", deq_bits, front);
                    $display("txn rnd deq: data=%h", deq_bits);
                end
            end
            if (enq_valid && enq_ready) begin
                sb.push_back(enq_bits);
                enq_cnt++;
                $display("txn rnd enq: data=%h", enq_bits);
            end
            tick();
            cyc++;
        end
        chk("rnd_finished", (enq_cnt == 40 && sb.size() == 0), 1);
        enq_valid = 1'b0; deq_ready = 1'b0;
        #1;
        chk("rnd_final_count", count, 0);

        // 6: reset with a read in flight
        for (int i = 0; i < 9; i++) begin
            enq_valid = 1'b1; enq_bits = 24'h500 + 24'(i);
            tick();
        end
        enq_valid = 1'b0; #1;
        chk("r6_count9", count, 9);
        deq_ready = 1'b1; #1;
        chk("r6_rd_issue", mem_en & !mem_wmode, 1);
        tick();
        deq_ready = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0; #1;
        chk("r6_count", count, 0);
        chk("r6_deq_valid", deq_valid, 0);
        chk("r6_deq_bits", deq_bits, 0);
        tick();
        chk("r6_no_stale_capture", deq_valid, 0);
        enq_valid = 1'b1; enq_bits = 24'h123456; #1;
        chk("r6_enq_ready", enq_ready, 1);
        chk("r6_bypass_no_mem", mem_en, 0);
        tick();
        enq_valid = 1'b0; #1;
        chk("r6_bypass_valid", deq_valid, 1);
        chk("r6_bypass_bits", deq_bits, 24'h123456);
        chk("r6_bypass_count", count, 1);
        $display("txn reset-recover: deq_bits=%h count=%0d", deq_bits, count);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
